pipe_ctrl: RTL and testbench

Hazard and stall controller that sequences the IF/ID and ID/EX pipeline registers of the five-stage core. It generates PC-write, register-enable and register-flush strobes from:
- load-use dependencies,
- taken branches/jumps resolved in EX,
- data-memory back-pressure,
- multi-cycle multiply/divide (MDU) operations held in EX.

It sits beside the decode stage and drives the `en`/`flush` pins of the PC, IF/ID and ID/EX registers. It also exposes a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Hazard and stall controller for the five-stage core. Drives
//                the enable/flush strobes of the PC, IF/ID and ID/EX
//                registers from load-use hazards, taken branches/jumps
//                resolved in EX, data-memory back-pressure and multi-cycle
//                multiply/divide operations held in EX. Also keeps a
//                saturating count of stall cycles for performance debug.
//
//  Optional feature (macro PIPE_CTRL_MDU_EN):
//      defined   : MDU state, down-counter and entry/exit logic present.
//      undefined : id_mdu ignored, no counter, state_o tied to 0.
//
//  Parameters:
//      MDU_LAT     EX occupancy of an MDU op in cycles (2..256).
//
//  Ports:
//      clk         in   1   core clock, rising edge
//      rst         in   1   synchronous active-high reset
//      id_valid    in   1   ID holds a real instruction
//      id_rs       in   5   ID source register rs
//      id_rt       in   5   ID source register rt
//      id_use_rs   in   1   ID instruction reads rs
//      id_use_rt   in   1   ID instruction reads rt
//      id_mdu      in   1   ID instruction is an MDU op
//      ex_load     in   1   EX instruction is a load
//      ex_rw       in   5   EX write-back register
//      ex_pcwr_en  in   1   EX resolved a taken branch/jump
//      mem_busy    in   1   data memory not ready, freeze everything
//      pc_en       out  1   PC write enable
//      ifid_en     out  1   IF/ID load enable
//      ifid_flush  out  1   IF/ID loads a bubble
//      idex_en     out  1   ID/EX load enable
//      idex_flush  out  1   ID/EX loads a bubble
//      state_o     out  2   FSM state: 0 = RUN, 1 = MDU
//      stall_cnt   out  16  saturating count of cycles with pc_en = 0
//
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_ctrl #(
    parameter int MDU_LAT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_mdu,
    input  logic        ex_load,
    input  logic [4:0]  ex_rw,
    input  logic        ex_pcwr_en,
    input  logic        mem_busy,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_en,
    output logic        idex_flush,
    output logic [1:0]  state_o,
    output logic [15:0] stall_cnt
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int               CNT_W      = $clog2(MDU_LAT);
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(MDU_LAT - 1);
    localparam logic [15:0]      C_SAT      = 16'hFFFF;

    // ------------------------------------------------------------------------
    // Internal signals
    // ------------------------------------------------------------------------
    logic        w_load_use;
    logic        w_mdu_busy;
    logic        w_pc_en;
    logic        w_ifid_en;
    logic        w_ifid_flush;
    logic        w_idex_en;
    logic        w_idex_flush;
    logic [15:0] r_stall_cnt;

    // ------------------------------------------------------------------------
    // Load-use detection. Register $zero is never a real dependency.
    // ------------------------------------------------------------------------
    assign w_load_use = id_valid & ex_load & (ex_rw != 5'd0) &
                        ((id_use_rs & (id_rs == ex_rw)) |
                         (id_use_rt & (id_rt == ex_rw)));

`ifdef PIPE_CTRL_MDU_EN
    // ------------------------------------------------------------------------
    // MDU occupancy FSM
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_RUN = 2'd0,
        ST_MDU = 2'd1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_mdu_entry;

    // EX is only blocked while the counter is still running; the cnt = 0
    // cycle of the MDU state behaves like RUN for strobe purposes.
    assign w_mdu_busy = (r_state == ST_MDU) && (r_cnt != '0);

    // An MDU op enters EX only if it actually moves out of ID this edge
    // (not frozen, not replaced by a bubble).
    assign w_mdu_entry = id_valid & id_mdu & w_idex_en & ~w_idex_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (!mem_busy) begin
            if (w_mdu_busy) begin
                w_cnt_nxt = r_cnt - 1'b1;
            end else if (w_mdu_entry) begin
                // Covers both a fresh entry from RUN and a back-to-back reload.
                w_state_nxt = ST_MDU;
                w_cnt_nxt   = C_CNT_LOAD;
            end else begin
                w_state_nxt = ST_RUN;
            end
        end
    end

    // The state reads as RUN for the whole reset cycle, even mid-op.
    assign state_o = rst ? 2'd0 : r_state;
`else
    logic w_unused;

    assign w_mdu_busy = 1'b0;
    assign state_o    = 2'd0;
    assign w_unused   = id_mdu | (|C_CNT_LOAD);
`endif

    // ------------------------------------------------------------------------
    // Strobe generation, highest priority first
    // ------------------------------------------------------------------------
    always_comb begin
        w_pc_en      = 1'b0;
        w_ifid_en    = 1'b0;
        w_ifid_flush = 1'b0;
        w_idex_en    = 1'b0;
        w_idex_flush = 1'b0;
        if (rst || mem_busy || w_mdu_busy) begin
            // Full freeze: every register holds its contents.
            w_pc_en = 1'b0;
        end else if (ex_pcwr_en) begin
            // Redirect the PC and kill the two wrong-path instructions.
            w_pc_en      = 1'b1;
            w_ifid_en    = 1'b1;
            w_ifid_flush = 1'b1;
            w_idex_en    = 1'b1;
            w_idex_flush = 1'b1;
        end else if (w_load_use) begin
            // Hold PC and IF/ID one cycle, slip a bubble into EX.
            w_idex_en    = 1'b1;
            w_idex_flush = 1'b1;
        end else begin
            w_pc_en   = 1'b1;
            w_ifid_en = 1'b1;
            w_idex_en = 1'b1;
        end
    end

    assign pc_en      = w_pc_en;
    assign ifid_en    = w_ifid_en;
    assign ifid_flush = w_ifid_flush;
    assign idex_en    = w_idex_en;
    assign idex_flush = w_idex_flush;

    // ------------------------------------------------------------------------
    // Saturating stall-cycle counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 16'd0;
        end else if (!w_pc_en && (r_stall_cnt != C_SAT)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_ctrl
//  Description : Directed self-checking bench for pipe_ctrl (MDU_LAT = 4).
//                Each step pushes its expected strobes/state/stall count to a
//                scoreboard queue and pops them when the outputs are sampled.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic        id_mdu;
    logic        ex_load;
    logic [4:0]  ex_rw;
    logic        ex_pcwr_en;
    logic        mem_busy;
    logic        pc_en;
    logic        ifid_en;
    logic        ifid_flush;
    logic        idex_en;
    logic        idex_flush;
    logic [1:0]  state_o;
    logic [15:0] stall_cnt;

    pipe_ctrl #(.MDU_LAT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_use_rs  (id_use_rs),
        .id_use_rt  (id_use_rt),
        .id_mdu     (id_mdu),
        .ex_load    (ex_load),
        .ex_rw      (ex_rw),
        .ex_pcwr_en (ex_pcwr_en),
        .mem_busy   (mem_busy),
        .pc_en      (pc_en),
        .ifid_en    (ifid_en),
        .ifid_flush (ifid_flush),
        .idex_en    (idex_en),
        .idex_flush (idex_flush),
        .state_o    (state_o),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    // Strobe vector order: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush}
    localparam logic [4:0] C_RUN   = 5'b11010;
    localparam logic [4:0] C_FRZ   = 5'b00000;
    localparam logic [4:0] C_LDUSE = 5'b00011;
    localparam logic [4:0] C_BR    = 5'b11111;

    typedef struct {
        string       tag;
        logic [4:0]  str;
        logic [1:0]  st;
        logic [15:0] sc;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] m_sc  = 16'd0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        n_chk++;
        assert (got === want)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, got, want);
        end
    endtask

    task automatic idle();
        id_valid   = 1'b0;
        id_rs      = 5'd0;
        id_rt      = 5'd0;
        id_use_rs  = 1'b0;
        id_use_rt  = 1'b0;
        id_mdu     = 1'b0;
        ex_load    = 1'b0;
        ex_rw      = 5'd0;
        ex_pcwr_en = 1'b0;
        mem_busy   = 1'b0;
    endtask

    // Called at a falling edge with inputs already driven. Samples 1 time unit
    // later, then advances past the rising edge and updates the stall model.
    task automatic cycle(input string tag, input logic [4:0] str, input logic [1:0] st);
        exp_t e;
        exp_t g;
        e.tag = tag;
        e.str = str;
        e.st  = st;
        e.sc  = m_sc;
        sb.push_back(e);
        #1;
        g = sb.pop_front();
        check({g.tag, "/strobes"},
              {11'd0, pc_en, ifid_en, ifid_flush, idex_en, idex_flush},
              {11'd0, g.str});
        check({g.tag, "/state"}, {14'd0, state_o}, {14'd0, g.st});
        check({g.tag, "/stall_cnt"}, stall_cnt, g.sc);
        @(posedge clk);
        if (rst)
            m_sc = 16'd0;
        else if (!str[4] && m_sc != 16'hFFFF)
            m_sc = m_sc + 16'd1;
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset overrides a pending branch.
        ex_pcwr_en = 1'b1;
        cycle("reset", C_FRZ, 2'd0);
        idle();
        rst = 1'b0;
        cycle("run", C_RUN, 2'd0);

        // Load-use on rs: exactly one stall, bubble into EX.
        id_valid = 1'b1; id_rs = 5'd5; id_use_rs = 1'b1; ex_load = 1'b1; ex_rw = 5'd5;
        cycle("lduse_rs", C_LDUSE, 2'd0);
        ex_load = 1'b0; ex_rw = 5'd0;
        cycle("lduse_clear", C_RUN, 2'd0);

        // $zero never stalls; unused operand never stalls.
        ex_load = 1'b1; ex_rw = 5'd0; id_rs = 5'd0;
        cycle("zero_reg", C_RUN, 2'd0);
        ex_rw = 5'd5; id_rs = 5'd5; id_use_rs = 1'b0;
        cycle("no_use", C_RUN, 2'd0);

        // Load-use on rt.
        id_rt = 5'd7; id_use_rt = 1'b1; ex_rw = 5'd7;
        cycle("lduse_rt", C_LDUSE, 2'd0);

        // Bubble in ID never stalls.
        id_valid = 1'b0;
        cycle("id_bubble", C_RUN, 2'd0);

        // Branch wins over load-use.
        id_valid = 1'b1; ex_pcwr_en = 1'b1;
        cycle("branch_vs_lduse", C_BR, 2'd0);
        ex_load = 1'b0;
        cycle("branch", C_BR, 2'd0);

        // Memory back-pressure wins over everything.
        ex_load = 1'b1; mem_busy = 1'b1;
        cycle("membusy_1", C_FRZ, 2'd0);
        ex_pcwr_en = 1'b0; ex_load = 1'b0;
        cycle("membusy_2", C_FRZ, 2'd0);
        idle();
        cycle("membusy_release", C_RUN, 2'd0);

`ifdef PIPE_CTRL_MDU_EN
        // Plain MDU op: 3 frozen cycles, branch ignored while counting.
        id_valid = 1'b1; id_mdu = 1'b1;
        cycle("div_issue", C_RUN, 2'd0);
        id_mdu = 1'b0;
        cycle("div_c3", C_FRZ, 2'd1);
        cycle("div_c2", C_FRZ, 2'd1);
        ex_pcwr_en = 1'b1;
        cycle("div_c1_br", C_FRZ, 2'd1);
        ex_pcwr_en = 1'b0;
        cycle("div_c0", C_RUN, 2'd1);
        cycle("div_done", C_RUN, 2'd0);

        // mem_busy mid-op holds the counter: 5 frozen cycles.
        id_mdu = 1'b1;
        cycle("divb_issue", C_RUN, 2'd0);
        id_mdu = 1'b0;
        cycle("divb_c3", C_FRZ, 2'd1);
        mem_busy = 1'b1;
        cycle("divb_busy1", C_FRZ, 2'd1);
        cycle("divb_busy2", C_FRZ, 2'd1);
        mem_busy = 1'b0;
        cycle("divb_c2", C_FRZ, 2'd1);
        cycle("divb_c1", C_FRZ, 2'd1);
        cycle("divb_c0", C_RUN, 2'd1);
        cycle("divb_done", C_RUN, 2'd0);

        // Back-to-back MDU ops reload the counter.
        id_mdu = 1'b1;
        cycle("b2b_issue", C_RUN, 2'd0);
        id_mdu = 1'b0;
        cycle("b2b_c3", C_FRZ, 2'd1);
        cycle("b2b_c2", C_FRZ, 2'd1);
        cycle("b2b_c1", C_FRZ, 2'd1);
        id_mdu = 1'b1;
        cycle("b2b_c0_reissue", C_RUN, 2'd1);
        id_mdu = 1'b0;
        cycle("b2b2_c3", C_FRZ, 2'd1);
        cycle("b2b2_c2", C_FRZ, 2'd1);
        cycle("b2b2_c1", C_FRZ, 2'd1);
        cycle("b2b2_c0", C_RUN, 2'd1);
        cycle("b2b2_done", C_RUN, 2'd0);

        // Reset at cnt = 2 aborts the op.
        id_mdu = 1'b1;
        cycle("rstm_issue", C_RUN, 2'd0);
        id_mdu = 1'b0;
        cycle("rstm_c3", C_FRZ, 2'd1);
        rst = 1'b1;
        cycle("rstm_reset", C_FRZ, 2'd0);
        rst = 1'b0;
        cycle("rstm_after", C_RUN, 2'd0);
        cycle("rstm_after2", C_RUN, 2'd0);
`else
        // Without the MDU feature id_mdu has no effect.
        id_valid = 1'b1; id_mdu = 1'b1;
        cycle("mdu_ignored_1", C_RUN, 2'd0);
        cycle("mdu_ignored_2", C_RUN, 2'd0);
`endif

        // Saturation: hold mem_busy long enough to pass 16'hFFFF.
        idle();
        mem_busy = 1'b1;
        repeat (65540) @(posedge clk);
        @(negedge clk);
        m_sc = 16'hFFFF;
        cycle("sat_1", C_FRZ, 2'd0);
        cycle("sat_2", C_FRZ, 2'd0);
        mem_busy = 1'b0;
        cycle("sat_release", C_RUN, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
